// File: rtl/tproj_link_receiver_if.sv
// Bundle between the link/match-engine side and the projection receiver.
// The master drives link words and read requests; the slave returns page data and status.
interface tproj_link_receiver_if #(
  parameter int WORD_W = 55,
  parameter int DATA_W = 48,
  parameter int BX_W   = 3,
  parameter int ADDR_W = 6,
  parameter int ERR_W  = 8
);
  logic [WORD_W-1:0] link_data;
  logic              link_valid;
  logic              rd_en;
  logic [BX_W-1:0]   rd_bx;
  logic [ADDR_W-1:0] rd_add;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   rd_nentries;
  logic [BX_W-1:0]   cur_bx;
  logic              synced;
  logic [ERR_W-1:0]  overflow_cnt;
  logic [ERR_W-1:0]  orphan_cnt;
  logic              fsm_state;  // 0 = UNSYNC, 1 = SYNC

  modport master (
    output link_data, link_valid, rd_en, rd_bx, rd_add,
    input  rd_data, rd_valid, rd_nentries, cur_bx, synced,
           overflow_cnt, orphan_cnt, fsm_state
  );

  modport slave (
    input  link_data, link_valid, rd_en, rd_bx, rd_add,
    output rd_data, rd_valid, rd_nentries, cur_bx, synced,
           overflow_cnt, orphan_cnt, fsm_state
  );
endinterface

// File: rtl/tproj_link_receiver.sv
// Receive side of the inter-sector projection link: rebuilds per-BX projection
// pages in a BX-banked RAM and serves them to the match engine by (BX, address).
module tproj_link_receiver #(
  parameter int WORD_W = 55,
  parameter int DATA_W = 48,
  parameter int BX_W   = 3,
  parameter int ADDR_W = 6,
  parameter int ERR_W  = 8
) (
  input  logic                        proc_clk,
  input  logic                        reset,
  tproj_link_receiver_if.slave        lnk
);

  // Handshake: a link word is consumed in every cycle where link_valid=1 (no
  // backpressure); a read issued with rd_en=1 in cycle N is answered in N+1
  // with rd_valid=1, and rd_valid=0 otherwise.

  localparam int NPAGES     = 2 ** BX_W;
  localparam int DEPTH      = 2 ** (BX_W + ADDR_W);
  localparam int PAGE_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PAGE_FULL = PAGE_DEPTH[ADDR_W:0];

  typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [BX_W-1:0]       cur_bx_q, cur_bx_d;
  logic [ADDR_W-1:0]     wr_add_q, wr_add_d;
  logic [ADDR_W:0]       nentries_q [NPAGES];
  logic [ADDR_W:0]       nentries_d [NPAGES];
  logic [ERR_W-1:0]      overflow_cnt_q, overflow_cnt_d;
  logic [ERR_W-1:0]      orphan_cnt_q, orphan_cnt_d;

  logic [DATA_W-1:0]     rd_data_q;
  logic                  rd_valid_q;
  logic [ADDR_W:0]       rd_nentries_q;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  wr_en;

  logic                  is_hdr;
  logic                  is_data;
  logic [BX_W-1:0]       hdr_bx;

  assign is_hdr  = lnk.link_valid && (lnk.link_data[WORD_W-1 -: 4] == 4'hF);
  assign is_data = lnk.link_valid && !is_hdr;
  assign hdr_bx  = lnk.link_data[DATA_W +: BX_W];

  always_comb begin
    state_d        = state_q;
    cur_bx_d       = cur_bx_q;
    wr_add_d       = wr_add_q;
    nentries_d     = nentries_q;
    overflow_cnt_d = overflow_cnt_q;
    orphan_cnt_d   = orphan_cnt_q;
    wr_en          = 1'b0;

    if (is_hdr) begin
      state_d            = SYNC;
      cur_bx_d           = hdr_bx;
      wr_add_d           = '0;
      nentries_d[hdr_bx] = '0;
    end else if (is_data) begin
      case (state_q)
        UNSYNC: begin
          if (orphan_cnt_q != '1) orphan_cnt_d = orphan_cnt_q + 1'b1;
        end
        SYNC: begin
          if (nentries_q[cur_bx_q] < PAGE_FULL) begin
            wr_en                = 1'b1;
            wr_add_d             = wr_add_q + 1'b1;
            nentries_d[cur_bx_q] = nentries_q[cur_bx_q] + 1'b1;
          end else if (overflow_cnt_q != '1) begin
            overflow_cnt_d = overflow_cnt_q + 1'b1;
          end
        end
        default: state_d = UNSYNC;
      endcase
    end
  end

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      state_q        <= UNSYNC;
      cur_bx_q       <= '0;
      wr_add_q       <= '0;
      overflow_cnt_q <= '0;
      orphan_cnt_q   <= '0;
      for (int i = 0; i < NPAGES; i++) nentries_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      cur_bx_q       <= cur_bx_d;
      wr_add_q       <= wr_add_d;
      overflow_cnt_q <= overflow_cnt_d;
      orphan_cnt_q   <= orphan_cnt_d;
      nentries_q     <= nentries_d;
    end
  end

  // RAM contents survive reset; the non-blocking read below gives read-first
  // behaviour on a same-address collision.
  always_ff @(posedge proc_clk) begin
    if (wr_en) mem[{cur_bx_q, wr_add_q}] <= lnk.link_data[DATA_W-1:0];
  end

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_nentries_q <= '0;
    end else begin
      rd_valid_q <= lnk.rd_en;
      if (lnk.rd_en) begin
        rd_data_q     <= mem[{lnk.rd_bx, lnk.rd_add}];
        rd_nentries_q <= nentries_q[lnk.rd_bx];
      end
    end
  end

  assign lnk.rd_data      = rd_data_q;
  assign lnk.rd_valid     = rd_valid_q;
  assign lnk.rd_nentries  = rd_nentries_q;
  assign lnk.cur_bx       = cur_bx_q;
  assign lnk.synced       = (state_q == SYNC);
  assign lnk.overflow_cnt = overflow_cnt_q;
  assign lnk.orphan_cnt   = orphan_cnt_q;
  assign lnk.fsm_state    = state_q;

endmodule

// File: tb/tb_tproj_link_receiver.sv
// Directed bench for the projection link receiver: page build, orphans,
// overflow, interleaved headers, read/write collision and mid-page reset.
module tb_tproj_link_receiver;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tproj_link_receiver_if #(
    .WORD_W(55), .DATA_W(48), .BX_W(3), .ADDR_W(6), .ERR_W(8)
  ) lnk ();

  tproj_link_receiver #(
    .WORD_W(55), .DATA_W(48), .BX_W(3), .ADDR_W(6), .ERR_W(8)
  ) dut (
    .proc_clk (clk),
    .reset    (rst_n),
    .lnk      (lnk.slave)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [54:0] hdr(input logic [2:0] bx);
    return {4'hF, bx, 48'h0};
  endfunction

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    lnk.link_valid  = 1'b0;
    lnk.link_data   = '0;
    lnk.rd_en       = 1'b0;
    lnk.rd_bx       = '0;
    lnk.rd_add      = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [54:0] w);
    @(negedge clk);
    lnk.link_valid = 1'b1;
    lnk.link_data  = w;
    lnk.rd_en      = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    lnk.link_valid = 1'b0;
    lnk.rd_en      = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] bx, input logic [5:0] add,
                         output logic [47:0] d, output logic [6:0] n,
                         output logic v);
    @(negedge clk);
    lnk.link_valid = 1'b0;
    lnk.rd_en      = 1'b1;
    lnk.rd_bx      = bx;
    lnk.rd_add     = add;
    @(negedge clk);
    lnk.rd_en = 1'b0;
    d = lnk.rd_data;
    n = lnk.rd_nentries;
    v = lnk.rd_valid;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (lnk.rd_data !== 48'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", lnk.rd_data); end
    checks++; if (lnk.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", lnk.rd_valid); end
    checks++; if (lnk.rd_nentries !== 7'd0) begin failures++; $display("FAIL reset_rd_nentries got=%0d exp=0", lnk.rd_nentries); end
    checks++; if (lnk.cur_bx !== 3'd0) begin failures++; $display("FAIL reset_cur_bx got=%0d exp=0", lnk.cur_bx); end
    checks++; if (lnk.synced !== 1'b0) begin failures++; $display("FAIL reset_synced got=%b exp=0", lnk.synced); end
    checks++; if (lnk.overflow_cnt !== 8'd0) begin failures++; $display("FAIL reset_overflow got=%0d exp=0", lnk.overflow_cnt); end
    checks++; if (lnk.orphan_cnt !== 8'd0) begin failures++; $display("FAIL reset_orphan got=%0d exp=0", lnk.orphan_cnt); end
  endtask

  task automatic test_basic_page();
    logic [47:0] exp_d [3];
    logic [47:0] d;
    logic [6:0]  n;
    logic        v;
    exp_d[0] = 48'h111; exp_d[1] = 48'h222; exp_d[2] = 48'h333;
    apply_reset();
    send(55'h78_0000_0000_0000);
    for (int i = 0; i < 3; i++) send({7'h0, exp_d[i]});
    idle();
    checks++; if (lnk.cur_bx !== 3'd0) begin failures++; $display("FAIL basic_cur_bx got=%0d exp=0", lnk.cur_bx); end
    checks++; if (lnk.synced !== 1'b1) begin failures++; $display("FAIL basic_synced got=%b exp=1", lnk.synced); end
    for (int i = 0; i < 3; i++) begin
      do_read(3'd0, 6'(i), d, n, v);
      checks++; if (d !== exp_d[i]) begin failures++; $display("FAIL basic_data%0d got=%h exp=%h", i, d, exp_d[i]); end
      checks++; if (n !== 7'd3) begin failures++; $display("FAIL basic_nent%0d got=%0d exp=3", i, n); end
      checks++; if (v !== 1'b1) begin failures++; $display("FAIL basic_valid%0d got=%b exp=1", i, v); end
    end
    @(negedge clk);
    checks++; if (lnk.rd_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", lnk.rd_valid); end
    checks++; if (lnk.rd_data !== 48'h333) begin failures++; $display("FAIL basic_data_hold got=%h exp=333", lnk.rd_data); end
  endtask

  task automatic test_orphan();
    logic [47:0] d;
    logic [6:0]  n;
    logic        v;
    apply_reset();
    for (int i = 1; i <= 5; i++) send(55'(i));
    idle();
    checks++; if (lnk.orphan_cnt !== 8'd5) begin failures++; $display("FAIL orphan_cnt got=%0d exp=5", lnk.orphan_cnt); end
    checks++; if (lnk.synced !== 1'b0) begin failures++; $display("FAIL orphan_synced got=%b exp=0", lnk.synced); end
    for (int b = 0; b < 8; b++) begin
      do_read(3'(b), 6'd0, d, n, v);
      checks++; if (n !== 7'd0) begin failures++; $display("FAIL orphan_nent_bx%0d got=%0d exp=0", b, n); end
    end
    send(hdr(3'd2));
    send(55'h0ABC);
    idle();
    do_read(3'd2, 6'd0, d, n, v);
    checks++; if (n !== 7'd1) begin failures++; $display("FAIL orphan_bx2_nent got=%0d exp=1", n); end
    checks++; if (d !== 48'h0ABC) begin failures++; $display("FAIL orphan_bx2_data got=%h exp=abc", d); end
    checks++; if (lnk.orphan_cnt !== 8'd5) begin failures++; $display("FAIL orphan_cnt_hold got=%0d exp=5", lnk.orphan_cnt); end
  endtask

  task automatic test_overflow();
    logic [47:0] d;
    logic [6:0]  n;
    logic        v;
    apply_reset();
    send(hdr(3'd5));
    for (int i = 1; i <= 70; i++) send(55'h5000 + 55'(i));
    idle();
    checks++; if (lnk.overflow_cnt !== 8'd6) begin failures++; $display("FAIL ovf_cnt got=%0d exp=6", lnk.overflow_cnt); end
    checks++; if (lnk.cur_bx !== 3'd5) begin failures++; $display("FAIL ovf_cur_bx got=%0d exp=5", lnk.cur_bx); end
    do_read(3'd5, 6'd63, d, n, v);
    checks++; if (n !== 7'd64) begin failures++; $display("FAIL ovf_nent got=%0d exp=64", n); end
    checks++; if (d !== 48'h5040) begin failures++; $display("FAIL ovf_last_data got=%h exp=5040", d); end
    do_read(3'd5, 6'd0, d, n, v);
    checks++; if (d !== 48'h5001) begin failures++; $display("FAIL ovf_first_data got=%h exp=5001", d); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 260; i++) send(55'h1);
    idle();
    checks++; if (lnk.orphan_cnt !== 8'hFF) begin failures++; $display("FAIL sat_orphan got=%0d exp=255", lnk.orphan_cnt); end
  endtask

  task automatic test_interleave();
    logic [47:0] d;
    logic [6:0]  n;
    logic        v;
    logic [47:0] exp_b2 [4];
    exp_b2[0] = 48'hB1; exp_b2[1] = 48'hB2; exp_b2[2] = 48'hB3; exp_b2[3] = 48'hB4;
    apply_reset();
    send(hdr(3'd1)); send(55'hA1); send(55'hA2);
    send(hdr(3'd2));
    for (int i = 0; i < 4; i++) send({7'h0, exp_b2[i]});
    send(hdr(3'd1)); send(55'hC1);
    idle();
    do_read(3'd1, 6'd0, d, n, v);
    checks++; if (n !== 7'd1) begin failures++; $display("FAIL il_bx1_nent got=%0d exp=1", n); end
    checks++; if (d !== 48'hC1) begin failures++; $display("FAIL il_bx1_data got=%h exp=c1", d); end
    for (int i = 0; i < 4; i++) begin
      do_read(3'd2, 6'(i), d, n, v);
      checks++; if (d !== exp_b2[i]) begin failures++; $display("FAIL il_bx2_data%0d got=%h exp=%h", i, d, exp_b2[i]); end
      checks++; if (n !== 7'd4) begin failures++; $display("FAIL il_bx2_nent%0d got=%0d exp=4", i, n); end
    end
  endtask

  // Relies on the page state left by test_interleave: BX1 holds 1 entry, RAM[{1,1}]=A2.
  task automatic test_back_to_back_rw();
    @(negedge clk);
    lnk.link_valid = 1'b1;
    lnk.link_data  = 55'hD1;
    lnk.rd_en      = 1'b1;
    lnk.rd_bx      = 3'd1;
    lnk.rd_add     = 6'd1;
    @(negedge clk);
    lnk.link_valid = 1'b0;
    checks++; if (lnk.rd_data !== 48'hA2) begin failures++; $display("FAIL rw_old_data got=%h exp=a2", lnk.rd_data); end
    checks++; if (lnk.rd_nentries !== 7'd1) begin failures++; $display("FAIL rw_old_nent got=%0d exp=1", lnk.rd_nentries); end
    @(negedge clk);
    lnk.rd_en = 1'b0;
    checks++; if (lnk.rd_data !== 48'hD1) begin failures++; $display("FAIL rw_new_data got=%h exp=d1", lnk.rd_data); end
    checks++; if (lnk.rd_nentries !== 7'd2) begin failures++; $display("FAIL rw_new_nent got=%0d exp=2", lnk.rd_nentries); end
  endtask

  task automatic test_valid_low_and_reset();
    logic [47:0] d;
    logic [6:0]  n;
    logic        v;
    @(negedge clk);
    lnk.link_valid = 1'b0;
    lnk.link_data  = hdr(3'd6);
    @(negedge clk);
    lnk.link_data  = 55'h99;
    @(negedge clk);
    checks++; if (lnk.cur_bx !== 3'd1) begin failures++; $display("FAIL vlow_cur_bx got=%0d exp=1", lnk.cur_bx); end
    do_read(3'd1, 6'd0, d, n, v);
    checks++; if (n !== 7'd2) begin failures++; $display("FAIL vlow_bx1_nent got=%0d exp=2", n); end
    send(55'hE1);
    idle();
    apply_reset();
    @(negedge clk);
    checks++; if (lnk.rd_data !== 48'h0) begin failures++; $display("FAIL mid_rd_data got=%h exp=0", lnk.rd_data); end
    checks++; if (lnk.rd_nentries !== 7'd0) begin failures++; $display("FAIL mid_rd_nent got=%0d exp=0", lnk.rd_nentries); end
    checks++; if (lnk.rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rd_valid got=%b exp=0", lnk.rd_valid); end
    checks++; if (lnk.cur_bx !== 3'd0) begin failures++; $display("FAIL mid_cur_bx got=%0d exp=0", lnk.cur_bx); end
    checks++; if (lnk.synced !== 1'b0) begin failures++; $display("FAIL mid_synced got=%b exp=0", lnk.synced); end
    send(55'hF00D);
    idle();
    checks++; if (lnk.orphan_cnt !== 8'd1) begin failures++; $display("FAIL mid_orphan got=%0d exp=1", lnk.orphan_cnt); end
    checks++; if (lnk.overflow_cnt !== 8'd0) begin failures++; $display("FAIL mid_overflow got=%0d exp=0", lnk.overflow_cnt); end
    do_read(3'd1, 6'd0, d, n, v);
    checks++; if (n !== 7'd0) begin failures++; $display("FAIL mid_bx1_nent got=%0d exp=0", n); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    lnk.link_valid = 1'b0;
    lnk.link_data  = '0;
    lnk.rd_en      = 1'b0;
    lnk.rd_bx      = '0;
    lnk.rd_add     = '0;
    test_reset();
    test_basic_page();
    test_orphan();
    test_overflow();
    test_saturate();
    test_interleave();
    test_back_to_back_rw();
    test_valid_low_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
